// File: rtl/inert_seq.sv
// Inertial-sensor sequencer: power-up wait, configuration writes, then four SPI byte
// reads per data-ready interrupt, presenting pitch rate and Z acceleration with vld.
module inert_seq #(
  parameter int PWRUP_W = 16,
  parameter int TMO_W   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [15:0] ptch_rate,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        init_done,
  output logic        tmo_err
);

  typedef enum logic [2:0] {
    PWRUP  = 3'd0,
    CFG    = 3'd1,
    CFG_WT = 3'd2,
    IDLE   = 3'd3,
    RD_WT  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [PWRUP_W-1:0] PWR_ZERO = {PWRUP_W{1'b0}};
  localparam logic [PWRUP_W-1:0] PWR_ONE  = {{(PWRUP_W-1){1'b0}}, 1'b1};
  localparam logic [PWRUP_W-1:0] PWR_MAX  = {PWRUP_W{1'b1}};
  localparam logic [TMO_W-1:0]   TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]   TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]   TMO_MAX  = {TMO_W{1'b1}};

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_cmd = 16'h0D02;
      2'd1:    cfg_cmd = 16'h1053;
      2'd2:    cfg_cmd = 16'h1150;
      2'd3:    cfg_cmd = 16'h1460;
      default: cfg_cmd = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] ridx);
    case (ridx)
      2'd0:    rd_cmd = 16'hA200;
      2'd1:    rd_cmd = 16'hA300;
      2'd2:    rd_cmd = 16'hAC00;
      2'd3:    rd_cmd = 16'hAD00;
      default: rd_cmd = 16'h0000;
    endcase
  endfunction

  state_t              state_q,     state_d;
  logic [PWRUP_W-1:0]  pwr_cnt_q,   pwr_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
  logic [1:0]          idx_q,       idx_d;
  logic [1:0]          ridx_q,      ridx_d;
  logic [3:0][7:0]     hold_q,      hold_d;
  logic                int_ff1_q,   int_ff1_d;
  logic                int_ff2_q,   int_ff2_d;
  logic                spi_wrt_q,   spi_wrt_d;
  logic [15:0]         spi_cmd_q,   spi_cmd_d;
  logic [15:0]         ptch_rate_q, ptch_rate_d;
  logic [15:0]         az_q,        az_d;
  logic                vld_q,       vld_d;
  logic                init_done_q, init_done_d;
  logic                tmo_err_q,   tmo_err_d;
  logic                tmo_max_hit;

  assign tmo_max_hit = (tmo_cnt_q == TMO_MAX);

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      pwr_cnt_q   <= PWR_ZERO;
      tmo_cnt_q   <= TMO_ZERO;
      idx_q       <= 2'd0;
      ridx_q      <= 2'd0;
      hold_q      <= 32'h0000_0000;
      int_ff1_q   <= 1'b0;
      int_ff2_q   <= 1'b0;
      spi_wrt_q   <= 1'b0;
      spi_cmd_q   <= 16'h0000;
      ptch_rate_q <= 16'h0000;
      az_q        <= 16'h0000;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      idx_q       <= idx_d;
      ridx_q      <= ridx_d;
      hold_q      <= hold_d;
      int_ff1_q   <= int_ff1_d;
      int_ff2_q   <= int_ff2_d;
      spi_wrt_q   <= spi_wrt_d;
      spi_cmd_q   <= spi_cmd_d;
      ptch_rate_q <= ptch_rate_d;
      az_q        <= az_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  // Next-state logic. Outputs are registered from the transition that issues them, so
  // spi_wrt is high in the first cycle of the state that waits on it and vld is high in DONE.
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    idx_d       = idx_q;
    ridx_d      = ridx_q;
    hold_d      = hold_q;
    int_ff1_d   = INT;
    int_ff2_d   = int_ff1_q;
    spi_wrt_d   = 1'b0;
    spi_cmd_d   = spi_cmd_q;
    ptch_rate_d = ptch_rate_q;
    az_d        = az_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == PWR_MAX) begin
          state_d   = CFG;
          idx_d     = 2'd0;
          spi_wrt_d = 1'b1;
          spi_cmd_d = cfg_cmd(2'd0);
          tmo_cnt_d = TMO_ZERO;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_ONE;
        end
      end

      CFG: begin
        state_d = CFG_WT;
      end

      CFG_WT: begin
        if (spi_done) begin
          if (idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d     = idx_q + 2'd1;
            state_d   = CFG;
            spi_wrt_d = 1'b1;
            spi_cmd_d = cfg_cmd(idx_q + 2'd1);
            tmo_cnt_d = TMO_ZERO;
          end
        end else if (tmo_max_hit) begin
          tmo_err_d = 1'b1;
          spi_wrt_d = 1'b1;
          tmo_cnt_d = TMO_ZERO;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end

      IDLE: begin
        if (int_ff2_q) begin
          state_d   = RD_WT;
          ridx_d    = 2'd0;
          spi_wrt_d = 1'b1;
          spi_cmd_d = rd_cmd(2'd0);
          tmo_cnt_d = TMO_ZERO;
        end else begin
          state_d = IDLE;
        end
      end

      RD_WT: begin
        if (spi_done) begin
          hold_d[ridx_q] = spi_rd_data[7:0];
          if (ridx_q == 2'd3) begin
            // Last byte bypasses the holding register so both words update together.
            state_d     = DONE;
            vld_d       = 1'b1;
            ptch_rate_d = {hold_q[1], hold_q[0]};
            az_d        = {spi_rd_data[7:0], hold_q[2]};
          end else begin
            ridx_d    = ridx_q + 2'd1;
            spi_wrt_d = 1'b1;
            spi_cmd_d = rd_cmd(ridx_q + 2'd1);
            tmo_cnt_d = TMO_ZERO;
          end
        end else if (tmo_max_hit) begin
          tmo_err_d = 1'b1;
          spi_wrt_d = 1'b1;
          tmo_cnt_d = TMO_ZERO;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end

      DONE: begin
        // DONE passes straight through IDLE: a still-high INT restarts reads at once.
        if (int_ff2_q) begin
          state_d   = RD_WT;
          ridx_d    = 2'd0;
          spi_wrt_d = 1'b1;
          spi_cmd_d = rd_cmd(2'd0);
          tmo_cnt_d = TMO_ZERO;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = PWRUP;
      end
    endcase
  end

  assign spi_wrt   = spi_wrt_q;
  assign spi_cmd   = spi_cmd_q;
  assign ptch_rate = ptch_rate_q;
  assign AZ        = az_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_inert_seq.sv
// Directed bench for inert_seq: a small SPI responder plus command/output scoreboards.
module tb_inert_seq;

  localparam int PWRUP_W = 4;
  localparam int TMO_W   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd_data = 16'h0000;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [15:0] ptch_rate;
  logic [15:0] AZ;
  logic        vld;
  logic        init_done;
  logic        tmo_err;

  int errors = 0;
  int checks = 0;
  int vld_seen = 0;
  int exp_vld = 0;
  logic [31:0] model_out = 32'h0;
  logic [15:0] exp_cmd_q[$];
  logic [31:0] exp_out_q[$];

  inert_seq #(.PWRUP_W(PWRUP_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .ptch_rate(ptch_rate), .AZ(AZ), .vld(vld),
    .init_done(init_done), .tmo_err(tmo_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (vld === 1'b1) vld_seen <= vld_seen + 1;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrt(input string tag, input int max_cyc, output int n);
    logic [15:0] e;
    n = 0;
    while (spi_wrt !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, " wrt"}, {31'd0, spi_wrt}, 32'd1);
    if (exp_cmd_q.size() > 0) e = exp_cmd_q.pop_front();
    else e = 16'hDEAD;
    check({tag, " cmd"}, {16'd0, spi_cmd}, {16'd0, e});
  endtask

  task automatic respond(input string tag, input int lat, input logic [7:0] b);
    logic [15:0] held;
    held = spi_cmd;
    for (int i = 0; i < lat; i++) begin
      tick();
      check({tag, " wrt one-shot"}, {31'd0, spi_wrt}, 32'd0);
      check({tag, " cmd held"}, {16'd0, spi_cmd}, {16'd0, held});
    end
    spi_done = 1'b1;
    spi_rd_data = {8'h5A, b};
    tick();
    spi_done = 1'b0;
    spi_rd_data = 16'h0000;
  endtask

  task automatic pulse_int(input int len);
    INT = 1'b1;
    repeat (len) tick();
    INT = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " spi_wrt"}, {31'd0, spi_wrt}, 32'd0);
    check({tag, " spi_cmd"}, {16'd0, spi_cmd}, 32'd0);
    check({tag, " ptch/AZ"}, {ptch_rate, AZ}, 32'd0);
    check({tag, " vld"}, {31'd0, vld}, 32'd0);
    check({tag, " init_done"}, {31'd0, init_done}, 32'd0);
    check({tag, " tmo_err"}, {31'd0, tmo_err}, 32'd0);
  endtask

  task automatic config_seq(input string tag, input bit glitch);
    int n;
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
    wait_wrt({tag, " cfg0"}, 40, n);
    check({tag, " pwrup latency"}, n, 32'd16);
    for (int i = 0; i < 4; i++) begin
      check({tag, " init_done low"}, {31'd0, init_done}, 32'd0);
      if (glitch && i == 1) pulse_int(2);
      respond({tag, " cfg"}, 6, 8'h00);
      if (i < 3) begin
        wait_wrt({tag, " cfg next"}, 0, n);
      end else begin
        check({tag, " init_done set"}, {31'd0, init_done}, 32'd1);
        check({tag, " no wrt after cfg"}, {31'd0, spi_wrt}, 32'd0);
      end
    end
  endtask

  task automatic read_seq(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int first_max,
                          input int exp_n, input bit drop_int);
    int n;
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAD00);
    exp_out_q.push_back({b1, b0, b3, b2});
    wait_wrt({tag, " rd0"}, first_max, n);
    check({tag, " rd0 latency"}, n, exp_n);
    if (drop_int) INT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respond({tag, " rd"}, 3, bytes[i]);
      if (i < 3) begin
        check({tag, " no vld mid"}, {31'd0, vld}, 32'd0);
        check({tag, " outputs stable"}, {ptch_rate, AZ}, model_out);
        wait_wrt({tag, " rd next"}, 0, n);
      end
    end
    check({tag, " vld"}, {31'd0, vld}, 32'd1);
    model_out = (exp_out_q.size() > 0) ? exp_out_q.pop_front() : 32'hDEAD_BEEF;
    exp_vld++;
    check({tag, " ptch/AZ"}, {ptch_rate, AZ}, model_out);
  endtask

  initial begin
    int n;
    int w;

    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Config with an INT glitch mid-configuration, then quiet IDLE and a stray done.
    config_seq("cfg1", 1'b1);
    w = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (spi_wrt === 1'b1) w++;
    end
    check("idle quiet after int glitch", w, 32'd0);
    spi_done = 1'b1;
    spi_rd_data = 16'hFFFF;
    tick();
    spi_done = 1'b0;
    spi_rd_data = 16'h0000;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (spi_wrt === 1'b1) w++;
    end
    check("stray done ignored", w, 32'd0);

    // Single INT pulse read.
    pulse_int(2);
    read_seq("rd1", 8'h34, 8'h12, 8'hCD, 8'hAB, 8, 1, 1'b0);
    check("rd1 value", {ptch_rate, AZ}, 32'h1234_ABCD);
    tick();
    check("rd1 vld one cycle", {31'd0, vld}, 32'd0);
    check("rd1 hold", {ptch_rate, AZ}, 32'h1234_ABCD);
    repeat (4) tick();

    // INT held high across DONE: back-to-back sequences.
    INT = 1'b1;
    read_seq("b2b1", 8'h11, 8'h22, 8'h33, 8'h44, 8, 3, 1'b0);
    read_seq("b2b2", 8'h55, 8'h66, 8'h77, 8'h88, 1, 1, 1'b1);
    repeat (6) tick();
    check("b2b stop", {31'd0, spi_wrt}, 32'd0);

    // Watchdog expiry on the third read.
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAD00);
    pulse_int(2);
    wait_wrt("tmo rd0", 8, n);
    respond("tmo rd0", 2, 8'hF0);
    wait_wrt("tmo rd1", 0, n);
    respond("tmo rd1", 2, 8'h0F);
    wait_wrt("tmo rd2", 0, n);
    check("tmo_err before expiry", {31'd0, tmo_err}, 32'd0);
    tick();
    wait_wrt("tmo reissue", (1 << TMO_W) + 8, n);
    check("tmo reissue gap", n + 1, 32'd1 << TMO_W);
    check("tmo_err set", {31'd0, tmo_err}, 32'd1);
    respond("tmo rd2", 2, 8'h00);
    wait_wrt("tmo rd3", 0, n);
    respond("tmo rd3", 2, 8'h80);
    check("tmo vld", {31'd0, vld}, 32'd1);
    model_out = 32'h0FF0_8000;
    exp_vld++;
    check("tmo ptch/AZ", {ptch_rate, AZ}, model_out);
    repeat (4) tick();

    // Reset in RD_WT after two completed reads.
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    pulse_int(2);
    wait_wrt("rst rd0", 8, n);
    respond("rst rd0", 2, 8'hAA);
    wait_wrt("rst rd1", 0, n);
    respond("rst rd1", 2, 8'hBB);
    wait_wrt("rst rd2", 0, n);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check_outputs_zero("mid-read reset");
    exp_cmd_q.delete();
    exp_out_q.delete();
    model_out = 32'h0;
    rst_n = 1'b1;
    config_seq("cfg2", 1'b0);
    check("no stale vld", vld_seen, exp_vld);

    pulse_int(2);
    read_seq("rd_final", 8'h01, 8'h80, 8'hFF, 8'h7F, 8, 1, 1'b0);
    check("final value", {ptch_rate, AZ}, 32'h8001_7FFF);
    check("init_done sticky", {31'd0, init_done}, 32'd1);
    repeat (2) tick();
    check("vld pulse count", vld_seen, exp_vld);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
